// File: rtl/ica_pkg.sv
// ica_pkg: shared constants, sample/state types and saturation helpers for the FastICA update unit
//   sat(v)      clamps a wide signed value into the DW-bit signed range
//   sat_clip(v) reports whether sat(v) would clamp
package ica_pkg;
  localparam int DW = 26;
  localparam int FRAC = 16;
  localparam int NSAMP = 128;
  localparam int LOG2N = 7;
  localparam int NCH = 4;
  localparam int PW = 2 * DW;
  localparam int WW = PW + 2;
  localparam int AW = DW + LOG2N;
  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [WW-1:0] wide_t;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, FINAL, DONE} state_t;
  localparam wide_t SMAX = wide_t'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam wide_t SMIN = ~SMAX;
  function automatic logic sat_clip(input wide_t v);
    return v > SMAX || v < SMIN;
  endfunction
  function automatic smp_t sat(input wide_t v);
    return v > SMAX ? smp_t'(SMAX) : v < SMIN ? smp_t'(SMIN) : smp_t'(v);
  endfunction
endpackage

// File: rtl/ica_fx_mul.sv
// ica_fx_mul: registered signed DW x DW fixed-point multiply
//   RAW=1: o_p is the full 2*DW-bit product
//   RAW=0: o_p = sat(a*b >>> FRAC), DW bits
//   ports: clk, rst_n (async active-low), i_a, i_b, o_p,
//          o_clip (only with ICA_SAT_FLAG_EN: registered clamp indicator)
module ica_fx_mul
  import ica_pkg::*;
#(
  parameter bit RAW = 1'b0,
  parameter int OW = RAW ? PW : DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [OW-1:0] o_p
`ifdef ICA_SAT_FLAG_EN
  , output logic        o_clip
`endif
);
  logic signed [PW-1:0] w_p;
  wide_t w_s;
  assign w_p = $signed(i_a) * $signed(i_b);
  assign w_s = wide_t'(w_p >>> FRAC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_p <= '0;
    else o_p <= RAW ? OW'(w_p) : OW'(sat(w_s));
`ifdef ICA_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_clip <= 1'b0;
    else o_clip <= !RAW && sat_clip(w_s);
`endif
endmodule

// File: rtl/ica_update_unit.sv
// ica_update_unit: FastICA one-unit update, w_new = E[x*y^3] - E[3y^2]*w over one RAM pass
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse, begins a pass when idle (latches w1..w4)
//   w1..w4         current weight vector
//   ram_en, ram_rw sample RAM enable (high NSAMP cycles) and write select (always 0)
//   q1..q4         RAM read data, valid one cycle after each enabled edge
//   busy, done     pass in progress; one-cycle completion pulse
//   wn1..wn4       updated weights, held until the next done
//   sat_flag       only with ICA_SAT_FLAG_EN: sticky clamp indicator for the pass
module ica_update_unit
  import ica_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] w1,
  input  logic [DW-1:0] w2,
  input  logic [DW-1:0] w3,
  input  logic [DW-1:0] w4,
  output logic          ram_en,
  output logic          ram_rw,
  input  logic [DW-1:0] q1,
  input  logic [DW-1:0] q2,
  input  logic [DW-1:0] q3,
  input  logic [DW-1:0] q4,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] wn1,
  output logic [DW-1:0] wn2,
  output logic [DW-1:0] wn3,
  output logic [DW-1:0] wn4
`ifdef ICA_SAT_FLAG_EN
  , output logic        sat_flag
`endif
);
  state_t r_state, w_nxt;
  logic [LOG2N-1:0] r_cnt;
  logic r_vld;
  logic [4:0] r_v;
  logic w_accept, w_fin1, w_fin2;
  smp_t w_w[NCH], w_q[NCH], r_w[NCH], r_x[4][NCH], w_t[NCH], w_mw[NCH];
  smp_t w_m[NCH], r_m[NCH], w_wn[NCH], r_wn[NCH];
  logic [PW-1:0] w_p[NCH];
  smp_t r_y, r_yd, w_y2, w_y3, r_gp, r_gp5, w_mg;
  logic signed [AW-1:0] r_acc[NCH], r_accg;
  wide_t w_sum, w_g3, w_mga, w_ma[NCH], w_wa[NCH];
  assign w_w = '{w1, w2, w3, w4};
  assign w_q = '{q1, q2, q3, q4};
  assign ram_en = r_state == READ;
  assign ram_rw = 1'b0;
  assign busy = r_state != IDLE && r_state != DONE;
  assign done = r_state == DONE;
  assign {wn1, wn2, wn3, wn4} = {r_wn[0], r_wn[1], r_wn[2], r_wn[3]};
  assign w_accept = r_state == IDLE && start;
  assign w_fin1 = r_state == FINAL && !r_cnt[0];
  assign w_fin2 = r_state == FINAL && r_cnt[0];
  // drain ends once the enable copy and every stage valid have emptied
  always_comb
    w_nxt = w_accept ? READ
          : (r_state == READ && r_cnt == LOG2N'(NSAMP - 1)) ? DRAIN
          : (r_state == DRAIN && !(r_vld || |r_v)) ? FINAL
          : w_fin2 ? DONE
          : r_state == DONE ? IDLE
          : r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_nxt != r_state ? '0 : r_cnt + LOG2N'(1);
    end
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NCH; k++) w_sum = w_sum + wide_t'($signed(w_p[k]));
    w_g3 = (wide_t'(w_y2) <<< 1) + wide_t'(w_y2);
    w_mga = wide_t'(r_accg >>> LOG2N);
    w_mg = sat(w_mga);
    for (int k = 0; k < NCH; k++) begin
      w_ma[k] = wide_t'(r_acc[k] >>> LOG2N);
      w_m[k] = sat(w_ma[k]);
      w_wa[k] = wide_t'(r_m[k]) - wide_t'(w_mw[k]);
      w_wn[k] = sat(w_wa[k]);
    end
  end
  // stage valids: r_v[0] after S1 ... r_v[4] after S5 (product t ready to accumulate)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_v <= '0;
      r_y <= '0;
      r_yd <= '0;
      r_gp <= '0;
      r_gp5 <= '0;
      r_accg <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_w[k] <= '0;
        r_acc[k] <= '0;
        r_m[k] <= '0;
        r_wn[k] <= '0;
        for (int s = 0; s < 4; s++) r_x[s][k] <= '0;
      end
    end else begin
      r_vld <= ram_en;
      r_v <= {r_v[3:0], r_vld};
      r_y <= sat(w_sum >>> FRAC);
      r_yd <= r_y;
      r_gp <= sat(w_g3);
      r_gp5 <= r_gp;
      r_accg <= w_accept ? '0 : r_v[4] ? r_accg + AW'(r_gp5) : r_accg;
      for (int k = 0; k < NCH; k++) begin
        r_w[k] <= w_accept ? w_w[k] : r_w[k];
        r_x[0][k] <= w_q[k];
        for (int s = 1; s < 4; s++) r_x[s][k] <= r_x[s-1][k];
        r_acc[k] <= w_accept ? '0 : r_v[4] ? r_acc[k] + AW'(w_t[k]) : r_acc[k];
        r_m[k] <= w_fin1 ? w_m[k] : r_m[k];
        r_wn[k] <= w_fin2 ? w_wn[k] : r_wn[k];
      end
    end
`ifdef ICA_SAT_FLAG_EN
  logic [NCH-1:0] c_p, c_t, c_mw, c_m, c_wn;
  logic c_y2, c_y3, w_hit, r_sat;
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      c_m[k] = sat_clip(w_ma[k]);
      c_wn[k] = sat_clip(w_wa[k]);
    end
    w_hit = |c_p
          || (r_v[0] && sat_clip(w_sum >>> FRAC))
          || (r_v[2] && (c_y2 || sat_clip(w_g3)))
          || (r_v[3] && c_y3)
          || (r_v[4] && |c_t)
          || (w_fin1 && (sat_clip(w_mga) || |c_m))
          || (w_fin2 && (|c_mw || |c_wn));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sat <= 1'b0;
    else r_sat <= w_accept ? 1'b0 : r_sat || w_hit;
  assign sat_flag = r_sat;
`endif
  ica_fx_mul u_y2 (
    .clk(clk), .rst_n(rst_n), .i_a(r_y), .i_b(r_y), .o_p(w_y2)
`ifdef ICA_SAT_FLAG_EN
    , .o_clip(c_y2)
`endif
  );
  // y is delayed one stage so it meets y2 of the same sample
  ica_fx_mul u_y3 (
    .clk(clk), .rst_n(rst_n), .i_a(w_y2), .i_b(r_yd), .o_p(w_y3)
`ifdef ICA_SAT_FLAG_EN
    , .o_clip(c_y3)
`endif
  );
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ica_fx_mul #(.RAW(1'b1)) u_p (
      .clk(clk), .rst_n(rst_n), .i_a(w_q[i]), .i_b(r_w[i]), .o_p(w_p[i])
`ifdef ICA_SAT_FLAG_EN
      , .o_clip(c_p[i])
`endif
    );
    ica_fx_mul u_t (
      .clk(clk), .rst_n(rst_n), .i_a(r_x[3][i]), .i_b(w_y3), .o_p(w_t[i])
`ifdef ICA_SAT_FLAG_EN
      , .o_clip(c_t[i])
`endif
    );
    // mg*w is formed straight from the final accumulator so it lands alongside m
    ica_fx_mul u_mw (
      .clk(clk), .rst_n(rst_n), .i_a(w_mg), .i_b(r_w[i]), .o_p(w_mw[i])
`ifdef ICA_SAT_FLAG_EN
      , .o_clip(c_mw[i])
`endif
    );
  end
endmodule

// File: tb/tb_ica_update_unit.sv
// tb_ica_update_unit: scoreboard bench for ica_update_unit with a behavioural sample RAM
module tb_ica_update_unit;
  localparam int DW = 26;
  localparam longint MX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DW-1:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
  logic [DW-1:0] q1, q2, q3, q4, wn1, wn2, wn3, wn4;
  logic ram_en, ram_rw, busy, done;
`ifdef ICA_SAT_FLAG_EN
  logic sat_flag;
`endif
  typedef struct { longint wn[4]; bit flag; } exp_t;
  exp_t sb[$];
  longint mem[128][4];
  longint tw[4];
  logic [6:0] addr;
  bit mflag;
  int n_chk = 0, n_err = 0;
  int run = 0, last_run = 0;
  bit rw_seen = 1'b0;
  always #5 clk = ~clk;
  ica_update_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .ram_en(ram_en), .ram_rw(ram_rw),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .busy(busy), .done(done),
    .wn1(wn1), .wn2(wn2), .wn3(wn3), .wn4(wn4)
`ifdef ICA_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );
  always @(posedge clk)
    if (ram_en) begin
      q1 <= DW'(mem[addr][0]);
      q2 <= DW'(mem[addr][1]);
      q3 <= DW'(mem[addr][2]);
      q4 <= DW'(mem[addr][3]);
      addr <= addr + 7'd1;
    end else addr <= 7'd0;
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic longint msat(input longint v);
    if (v > MX) begin mflag = 1'b1; return MX; end
    if (v < -MX - 1) begin mflag = 1'b1; return -MX - 1; end
    return v;
  endfunction
  function automatic exp_t model();
    exp_t e;
    longint acc[4], accg, s, y, y2, y3, mg, m;
    mflag = 1'b0;
    accg = 0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    for (int n = 0; n < 128; n++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += mem[n][i] * tw[i];
      y = msat(s >>> 16);
      y2 = msat((y * y) >>> 16);
      y3 = msat((y2 * y) >>> 16);
      accg += msat(3 * y2);
      for (int i = 0; i < 4; i++) acc[i] += msat((mem[n][i] * y3) >>> 16);
    end
    mg = msat(accg >>> 7);
    for (int i = 0; i < 4; i++) begin
      m = msat(acc[i] >>> 7);
      e.wn[i] = msat(m - msat((mg * tw[i]) >>> 16));
    end
    e.flag = mflag;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (ram_en) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (ram_rw !== 1'b0) rw_seen = 1'b1;
    if (rst_n && done) begin
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("wn1", $signed(wn1), e.wn[0]);
        check("wn2", $signed(wn2), e.wn[1]);
        check("wn3", $signed(wn3), e.wn[2]);
        check("wn4", $signed(wn4), e.wn[3]);
`ifdef ICA_SAT_FLAG_EN
        check("sat_flag", sat_flag, e.flag);
`endif
      end
    end
  end
  task automatic fill(input longint a, input longint b, input bit alt, input bit rnd);
    logic [DW-1:0] r;
    for (int n = 0; n < 128; n++)
      for (int i = 0; i < 4; i++) begin
        r = DW'($urandom);
        mem[n][i] = rnd ? longint'($signed(r)) : i == 0 ? ((alt && n % 2 == 1) ? -a : a) : i == 1 ? b : 0;
      end
  endtask
  task automatic set_w(input longint a, input longint b, input longint c, input longint d);
    tw[0] = a; tw[1] = b; tw[2] = c; tw[3] = d;
  endtask
  task automatic run_pass(input bit dup, input bit late);
    int cyc;
    @(negedge clk);
    w1 = DW'(tw[0]); w2 = DW'(tw[1]); w3 = DW'(tw[2]); w4 = DW'(tw[3]);
    start = 1'b1;
    sb.push_back(model());
    @(negedge clk);
    start = 1'b0;
    w1 = DW'($urandom); w2 = DW'($urandom); w3 = DW'($urandom); w4 = DW'($urandom);
    check("busy_after_start", busy, 1);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = dup && cyc == 40;
    end
    check("latency", cyc, 138);
    start = late;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_rw", ram_rw, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wn", {wn1, wn2, wn3, wn4}, 0);
    rst_n = 1'b1;
    fill(65536, 0, 1'b0, 1'b0);
    set_w(65536, 0, 0, 0);
    run_pass(1'b0, 1'b0);
    check("case1_wn1", $signed(wn1), -131072);
    fill(65536, 32768, 1'b0, 1'b0);
    run_pass(1'b0, 1'b1);
    check("case2_wn2", $signed(wn2), 32768);
    fill(65536, 0, 1'b1, 1'b0);
    run_pass(1'b0, 1'b0);
    check("case3_wn1", $signed(wn1), -131072);
    check("ram_en_run", last_run, 128);
    check("ram_rw_zero", rw_seen, 0);
    fill(65536, 0, 1'b0, 1'b0);
    @(negedge clk);
    w1 = 26'd65536; w2 = '0; w3 = '0; w4 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_read_ram_en", ram_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ram_en", ram_en, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_wn1", $signed(wn1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    run_pass(1'b1, 1'b0);
    check("rerun_wn1", $signed(wn1), -131072);
    fill(0, 0, 1'b0, 1'b1);
    set_w(0, 0, 0, 0);
    run_pass(1'b0, 1'b0);
`ifdef ICA_SAT_FLAG_EN
    check("zero_w_flag", sat_flag, 0);
`endif
    fill(6553600, 0, 1'b0, 1'b0);
    set_w(65536, 0, 0, 0);
    run_pass(1'b0, 1'b0);
`ifdef ICA_SAT_FLAG_EN
    check("big_x_flag", sat_flag, 1);
`endif
    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
